// File: rtl/regfile_scoreboarded_pkg.sv
// Shared constants and types for the scoreboarded register file and its dump engine.
package regfile_scoreboarded_pkg;

  // Register width used unless the instantiating core overrides it.
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Architectural zero register: reads as zero, ignores writes, never busy.
  localparam int REG_ZERO = 0;

  // Dump engine states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: streams every register out in index order over a valid/ready handshake.
// The parent supplies the value of the next index (including a write landing this cycle),
// which is captured when the current beat is accepted.
module regfile_dump_fsm
  import regfile_scoreboarded_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic                  o_active,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_rd_idx,
  input  logic [DATA_WIDTH-1:0] i_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

  dump_state_e           r_state;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  // The parent is always asked for the index that follows the beat on display.
  assign o_rd_idx = r_addr + ONE_IDX;

  assign o_valid  = r_valid;
  assign o_active = (r_state == ST_SEND);
  assign o_addr   = r_addr;
  assign o_data   = r_data;

  // Dump state machine: start on a pulse in IDLE, advance one index per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_SEND;
            r_valid <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
          end
        end
        ST_SEND: begin
          if (r_valid && i_ready) begin
            if (r_addr == LAST_IDX) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
            end else begin
              r_addr <= o_rd_idx;
              r_data <= i_rd_data;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_scoreboarded.sv
// Integer register file with two combinational read ports, one write port with optional
// write-to-read bypass, hard-wired zero register, a per-register busy scoreboard and a
// valid/ready dump engine.
module regfile_scoreboarded
  import regfile_scoreboarded_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  issue,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_active
);

  localparam int                    NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;

  logic                  w_wr_en;
  logic                  w_issue_en;
  logic [ADDR_WIDTH-1:0] w_dump_idx;
  logic [DATA_WIDTH-1:0] w_dump_rdata;

  // Writes and issues aimed at the zero register are dropped here once for all users.
  assign w_wr_en    = wr && (rd != ZERO_IDX);
  assign w_issue_en = issue && (issue_rd != ZERO_IDX);

  // Register storage.
  // NOTE: the array is reset on purpose so every register reads zero straight after reset;
  // this keeps it in flops, which the combinational read ports need anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[rd] <= wd;
    end
  end

  // Busy scoreboard: writeback clears, issue sets; an issue to the same index wins.
  // NOTE: both updates are non-blocking, so the later statement in program order takes
  // effect when they target the same bit -- the issue set is placed last deliberately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_wr_en)    r_busy[rd]       <= 1'b0;
      if (w_issue_en) r_busy[issue_rd] <= 1'b1;
    end
  end

  // Read port 1: zero register, optional same-cycle bypass, else stored value.
  // NOTE: the stored value is assigned first so every path drives rd1 and no latch forms.
  always_comb begin
    rd1 = r_regs[rs1];
    if (rs1 == ZERO_IDX)                  rd1 = '0;
    else if (BYPASS && wr && (rd == rs1)) rd1 = wd;
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2 = r_regs[rs2];
    if (rs2 == ZERO_IDX)                  rd2 = '0;
    else if (BYPASS && wr && (rd == rs2)) rd2 = wd;
  end

  // Busy outputs show the registered bits only; an issue in flight is not forwarded.
  assign busy1 = r_busy[rs1];
  assign busy2 = r_busy[rs2];

  // Dump read port: always forwards a landing write so the captured beat is never stale.
  always_comb begin
    w_dump_rdata = r_regs[w_dump_idx];
    if (w_dump_idx == ZERO_IDX)                 w_dump_rdata = '0;
    else if (w_wr_en && (rd == w_dump_idx))     w_dump_rdata = wd;
  end

  regfile_dump_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dump_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_start   (dump_start),
    .i_ready   (dump_ready),
    .o_valid   (dump_valid),
    .o_active  (dump_active),
    .o_addr    (dump_addr),
    .o_data    (dump_data),
    .o_rd_idx  (w_dump_idx),
    .i_rd_data (w_dump_rdata)
  );

endmodule
